// File: rtl/l2_victim_buffer_pkg.sv
// Shared types and widths for the L2 victim (write-back) buffer.
// Line offset width follows from the line size in bytes.
package l2_victim_buffer_pkg;

    localparam int unsigned VB_ADDR_WIDTH = 16;
    localparam int unsigned VB_LINE_WIDTH = 128;

    typedef logic [VB_ADDR_WIDTH-1:0] lc3b_word;
    typedef logic [VB_LINE_WIDTH-1:0] lc3b_L2_line;

    typedef enum logic [1:0] {
        VB_IDLE     = 2'd0,
        VB_READ_MEM = 2'd1,
        VB_DRAIN    = 2'd2
    } vb_state_t;

endpackage

// File: rtl/l2_victim_buffer_control.sv
// Victim buffer sequencing: L2 handshake decode, buffer load/clear strobes
// and the memory-side read/drain FSM.
module l2_victim_buffer_control
    import l2_victim_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    input  logic line_match,
    input  logic buf_valid,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic buf_load,
    output logic buf_clear,
    output logic pmem_read,
    output logic pmem_write
);

    vb_state_t state;
    vb_state_t state_next;
    logic      req_rd;
    logic      req_wr;

    // Both strobes high is treated the same as no request.
    assign req_rd = mem_read & ~mem_write;
    assign req_wr = mem_write & ~mem_read;

    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            VB_IDLE: begin
                if (req_rd) begin
                    if (line_match) mem_resp   = 1'b1;
                    else            state_next = VB_READ_MEM;
                end else if (req_wr) begin
                    if (!buf_valid || line_match) begin
                        buf_load = 1'b1;
                        mem_resp = 1'b1;
                    end else begin
                        state_next = VB_DRAIN;
                    end
                end else if (buf_valid) begin
                    state_next = VB_DRAIN;
                end
            end
            VB_READ_MEM: begin
                if (pmem_resp) begin
                    mem_resp   = 1'b1;
                    state_next = VB_IDLE;
                end
            end
            VB_DRAIN: begin
                if (req_rd && line_match) mem_resp = 1'b1;
                if (pmem_resp) begin
                    buf_clear  = 1'b1;
                    state_next = VB_IDLE;
                end
            end
            default: state_next = VB_IDLE;
        endcase
    end

    // Memory strobes are registered images of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= VB_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            state      <= state_next;
            pmem_read  <= (state_next == VB_READ_MEM);
            pmem_write <= (state_next == VB_DRAIN);
        end
    end

endmodule

// File: rtl/l2_victim_buffer.sv
// Single-entry victim buffer between L2 and physical memory: holds one
// evicted line, serves hits on it and drains it when memory is idle.
module l2_victim_buffer
    import l2_victim_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = VB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = VB_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned TAG_W    = ADDR_WIDTH - OFFSET_W;

    logic                  buf_valid;
    logic [TAG_W-1:0]      buf_tag;
    logic [LINE_WIDTH-1:0] buf_data;
    logic                  line_match;
    logic                  buf_load;
    logic                  buf_clear;

    assign line_match = buf_valid && (mem_address[ADDR_WIDTH-1:OFFSET_W] == buf_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_address[ADDR_WIDTH-1:OFFSET_W];
            buf_data  <= mem_wdata;
        end else if (buf_clear) begin
            buf_valid <= 1'b0;
        end
    end

    // pmem_read is only high in READ_MEM, so it doubles as the data/address select.
    assign mem_rdata    = pmem_read ? pmem_rdata : buf_data;
    assign pmem_address = pmem_read ? mem_address : {buf_tag, {OFFSET_W{1'b0}}};
    assign pmem_wdata   = buf_data;

    l2_victim_buffer_control u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .line_match (line_match),
        .buf_valid  (buf_valid),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .buf_load   (buf_load),
        .buf_clear  (buf_clear),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write)
    );

endmodule
